// File: rtl/wrapper_pkg.sv
// rtl/wrapper_pkg.sv - shared constants, state encodings and helpers for the accelerator wrappers
//
// Purpose: common definitions used by the input and output wrappers.
// Contents:
//   state_t  - 2-bit handshake FSM encodings (IDLE, SEND, HOLD)
//   BYTE_W   - width of one serialised byte
//   clog2    - ceiling log2 for sizing counters
package wrapper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_shift_reg.sv
// rtl/out_shift_reg.sv - parallel-load register that shifts right one byte at a time
//
// Purpose: holds the captured result and presents its lowest byte.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (clears to 0)
//   load      - load din into the register
//   shift     - shift the register right by one byte (zero fill)
//   din       - parallel load data, WIDTH bits
//   low       - registered lowest byte of the register
module out_shift_reg
  import wrapper_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [7:0]       low
);

  logic [WIDTH-1:0] sh;

  // load wins over shift; the FSM never asserts both in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else if (shift) begin
      sh <= sh >> BYTE_W;
    end
  end

  assign low = sh[7:0];

endmodule

// File: rtl/wrapper_output.sv
// rtl/wrapper_output.sv - captures the accelerator result and serialises it byte-wise
//
// Purpose: on the rising edge of ready, latch result and send it low byte first
// over an 8-bit bus using a four-phase ordy/oac handshake.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   ready     - accelerator done; its 0->1 edge marks a valid result
//   result    - accelerator result, RESULT_W bits
//   oac       - consumer acknowledge for the byte on obus
//   obus      - current output byte (registered)
//   ordy      - obus holds a valid byte
//   obe       - output buffer empty, a new result can be accepted
//   ovf       - sticky overrun: a result arrived while busy and was dropped
module wrapper_output
  import wrapper_pkg::*;
#(
  parameter int RESULT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [RESULT_W-1:0] result,
  input  logic                oac,
  output logic [7:0]          obus,
  output logic                ordy,
  output logic                obe,
  output logic                ovf
);

  localparam int NBYTES = RESULT_W / BYTE_W;
  localparam int IDX_W  = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             ready_q;
  logic             cap;
  logic             load;
  logic             shift;
  logic [IDX_W-1:0] idx_q;

  // ready_q resets high so a ready already asserted out of reset is not a capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= ready;
    end
  end

  assign cap = ready & ~ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // oac already high on entry counts as the acknowledge
        if (oac) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!oac) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            shift   = 1'b1;
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (load) begin
      idx_q <= '0;
    end else if (shift) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // a capture while busy is dropped; only the flag records it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (cap && (state_q != IDLE)) begin
      ovf <= 1'b1;
    end
  end

  out_shift_reg #(
    .WIDTH(RESULT_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (result),
    .low   (obus)
  );

  // Moore decode straight from the state register
  assign ordy = (state_q == SEND);
  assign obe  = (state_q == IDLE);

endmodule
